// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add MULU and restoring DIVU
module alu_multicycle #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             div0_o
);

    typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [WIDTH-1:0]   result_hi_q, result_hi_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               div0_q, div0_d;

    logic               accept;
    logic               iter_op;
    logic [WIDTH-1:0]   sum, diff;
    logic [WIDTH-1:0]   alu_res, alu_hi;
    logic               alu_ovf, alu_div0;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh, div_diff;
    logic [WIDTH-1:0]   step_hi, step_lo;

    assign accept  = start_i && (state_q != ITER);
    assign iter_op = (ctrl_i == OP_MULU) || ((ctrl_i == OP_DIVU) && (src2_i != '0));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_div_q    <= 1'b0;
            opnd_q      <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            div0_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_div_q    <= is_div_d;
            opnd_q      <= opnd_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            div0_q      <= div0_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) state_d = iter_op ? ITER : DONE;
                else        state_d = IDLE;
            end
            ITER:    if (cnt_q == CNT_W'(1)) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q == ITER);
        done_o = (state_q == DONE);
    end

    // Single-cycle ALU evaluated on the live inputs at acceptance.
    always_comb begin
        sum      = src1_i + src2_i;
        diff     = src1_i - src2_i;
        alu_res  = '0;
        alu_hi   = '0;
        alu_ovf  = 1'b0;
        alu_div0 = 1'b0;
        case (ctrl_i)
            OP_AND:  alu_res = src1_i & src2_i;
            OP_OR:   alu_res = src1_i | src2_i;
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (src1_i[WIDTH-1] == src2_i[WIDTH-1]) && (sum[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (src1_i[WIDTH-1] != src2_i[WIDTH-1]) && (diff[WIDTH-1] != src1_i[WIDTH-1]);
            end
            OP_SLT:  alu_res = WIDTH'($signed(src1_i) < $signed(src2_i));
            OP_SLTU: alu_res = WIDTH'(src1_i < src2_i);
            OP_DIVU: begin
                alu_res  = '1;
                alu_hi   = src1_i;
                alu_div0 = 1'b1;
            end
            default: alu_res = '0;
        endcase
    end

    // One iteration: MULU keeps {hi,lo} as partial product / multiplier,
    // DIVU keeps {hi,lo} as partial remainder / dividend-becoming-quotient.
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
        div_sh   = {hi_q, lo_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, opnd_q};
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                step_hi = div_diff[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = div_sh[WIDTH-1:0];
                step_lo = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        cnt_d       = cnt_q;
        is_div_d    = is_div_q;
        opnd_d      = opnd_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        div0_d      = div0_q;
        if (accept) begin
            if (iter_op) begin
                cnt_d    = CNT_W'(WIDTH);
                is_div_d = (ctrl_i == OP_DIVU);
                hi_d     = '0;
                opnd_d   = (ctrl_i == OP_DIVU) ? src2_i : src1_i;
                lo_d     = (ctrl_i == OP_DIVU) ? src1_i : src2_i;
            end else begin
                result_d    = alu_res;
                result_hi_d = alu_hi;
                zero_d      = (alu_res == '0);
                ovf_d       = alu_ovf;
                div0_d      = alu_div0;
            end
        end else if (state_q == ITER) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                result_d    = step_lo;
                result_hi_d = step_hi;
                zero_d      = (step_lo == '0);
                ovf_d       = 1'b0;
                div0_d      = 1'b0;
            end
        end
    end

    assign result_o    = result_q;
    assign result_hi_o = result_hi_q;
    assign zero_o      = zero_q;
    assign overflow_o  = ovf_q;
    assign div0_o      = div0_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - randomized self-checking bench for alu_multicycle against an arithmetic reference model
module tb_alu_multicycle;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 64'sd1;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic         start_i = 1'b0;
    logic [W-1:0] src1_i = '0;
    logic [W-1:0] src2_i = '0;
    logic [3:0]   ctrl_i = '0;
    logic         busy_o, done_o, zero_o, overflow_o, div0_o;
    logic [W-1:0] result_o, result_hi_o;

    alu_multicycle #(.WIDTH(W), .CNT_W(6)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
        .src1_i(src1_i), .src2_i(src2_i), .ctrl_i(ctrl_i),
        .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
        .result_hi_o(result_hi_o), .zero_o(zero_o),
        .overflow_o(overflow_o), .div0_o(div0_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [W-1:0] r;
        logic [W-1:0] h;
        logic         ovf;
        logic         d0;
        logic [7:0]   lat;
    } exp_t;

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] prev_r = '0, prev_h = '0;
    logic [2:0]   prev_f = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        longint s;
        logic [63:0] p;
        e = '0;
        e.lat = 8'd1;
        case (op)
            4'b0000: e.r = a & b;
            4'b0001: e.r = a | b;
            4'b0010: begin
                s = longint'($signed(a)) + longint'($signed(b));
                e.r = a + b;
                e.ovf = (s > SMAX) || (s < SMIN);
            end
            4'b0110: begin
                s = longint'($signed(a)) - longint'($signed(b));
                e.r = a - b;
                e.ovf = (s > SMAX) || (s < SMIN);
            end
            4'b0111: e.r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: e.r = (a < b) ? 32'd1 : 32'd0;
            4'b1000: begin
                p = {32'd0, a} * {32'd0, b};
                e.r = p[31:0];
                e.h = p[63:32];
                e.lat = 8'(W + 1);
            end
            4'b1001: begin
                if (b == 0) begin
                    e.r = '1;
                    e.h = a;
                    e.d0 = 1'b1;
                end else begin
                    e.r = a / b;
                    e.h = a % b;
                    e.lat = 8'(W + 1);
                end
            end
            default: e.r = '0;
        endcase
        return e;
    endfunction

    // Presents the op for one edge, then waits for done_o; returns in the done cycle with start_i low.
    task automatic run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
        exp_t e;
        int lat;
        e = model(op, a, b);
        start_i = 1'b1;
        ctrl_i  = op;
        src1_i  = a;
        src2_i  = b;
        step;
        lat = 1;
        start_i = 1'b0;
        while (!done_o && lat < 100) begin
            check("busy_iter", 64'(busy_o), 64'(1));
            check("hold_res", {result_o, result_hi_o}, {prev_r, prev_h});
            check("hold_flags", 64'({zero_o, overflow_o, div0_o}), 64'(prev_f));
            if (disturb) begin
                start_i = 1'($urandom_range(0, 1));
                src1_i  = $urandom;
                src2_i  = $urandom;
                ctrl_i  = 4'($urandom);
            end
            step;
            lat++;
        end
        start_i = 1'b0;
        check("latency", 64'(lat), 64'(e.lat));
        check("done", 64'(done_o), 64'(1));
        check("busy_at_done", 64'(busy_o), 64'(0));
        check("result", 64'(result_o), 64'(e.r));
        check("result_hi", 64'(result_hi_o), 64'(e.h));
        check("flags", 64'({zero_o, overflow_o, div0_o}), 64'({e.r == 0, e.ovf, e.d0}));
        prev_r = e.r;
        prev_h = e.h;
        prev_f = {e.r == 0, e.ovf, e.d0};
    endtask

    task automatic idle;
        step;
        check("done_pulse", 64'(done_o), 64'(0));
        check("idle_busy", 64'(busy_o), 64'(0));
    endtask

    function automatic logic [W-1:0] rnd_opnd;
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return W'($urandom_range(1, 15));
            2:       return {1'b1, 31'($urandom)};
            3:       return '1;
            default: return $urandom;
        endcase
    endfunction

    logic [3:0] ops [12] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'h3, 4'h8, 4'h9, 4'h9, 4'h8, 4'h4, 4'hF};

    initial begin
        #12;
        check("rst_res", {result_o, result_hi_o}, 64'd0);
        check("rst_ctl", 64'({busy_o, done_o, zero_o, overflow_o, div0_o}), 64'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        run(4'b0010, 32'h7FFFFFFF, 32'h1, 1'b0);
        idle;
        run(4'b0110, 32'd5, 32'd5, 1'b0);
        run(4'b0111, 32'hFFFFFFFF, 32'd1, 1'b0);
        run(4'b0011, 32'hFFFFFFFF, 32'd1, 1'b0);
        idle;
        run(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        idle;
        run(4'b1001, 32'd100, 32'd7, 1'b1);
        run(4'b1001, 32'd9, 32'd0, 1'b0);
        idle;

        // Abort a MULU in its tenth ITER cycle.
        start_i = 1'b1;
        ctrl_i  = 4'b1000;
        src1_i  = $urandom;
        src2_i  = $urandom;
        step;
        start_i = 1'b0;
        repeat (9) step;
        check("pre_abort_busy", 64'(busy_o), 64'(1));
        rst_i = 1'b0;
        #1;
        check("abort_res", {result_o, result_hi_o}, 64'd0);
        check("abort_ctl", 64'({busy_o, done_o, zero_o, overflow_o, div0_o}), 64'd0);
        repeat (3) begin
            step;
            check("abort_no_done", 64'({busy_o, done_o}), 64'd0);
        end
        rst_i = 1'b1;
        prev_r = '0;
        prev_h = '0;
        prev_f = '0;
        run(4'b0010, $urandom, $urandom, 1'b0);
        idle;

        for (int i = 0; i < 60; i++) begin
            run(ops[$urandom_range(0, 11)], rnd_opnd(), rnd_opnd(), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) idle;
        end
        idle;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width in bits (legal 8..64).
REQ-002 Parameter: CNT_W, default 6, iteration counter width; SHALL satisfy 2**CNT_W > WIDTH.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  request; accepted only when busy_o=0.
REQ-006 src1_i  input  WIDTH  operand A, sampled on acceptance.
REQ-007 src2_i  input  WIDTH  operand B, sampled on acceptance.
REQ-008 ctrl_i  input  4  opcode, sampled on acceptance.
REQ-009 busy_o  output  1  high while an iterative op is in progress.
REQ-010 done_o  output  1  one-cycle pulse, result valid.
REQ-011 result_o  output  WIDTH  primary result (low product, quotient, or ALU result).
REQ-012 result_hi_o  output  WIDTH  high product, remainder, else 0.
REQ-013 zero_o  output  1  registered (result_o==0), updated with result_o.
REQ-014 overflow_o  output  1  signed overflow for ADD/SUB, else 0.
REQ-015 div0_o  output  1  DIVU with src2=0, else 0.

Function
REQ-016 Opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT signed, 0011 SLTU unsigned, 1000 MULU, 1001 DIVU; any other code SHALL produce result_o=0, done in 1 cycle.
REQ-017 States: IDLE, ITER, DONE; reset state IDLE.
REQ-018 IDLE/DONE + start_i + single-cycle opcode -> DONE next cycle with results registered; done_o=1 for exactly that cycle.
REQ-019 IDLE/DONE + start_i + MULU/DIVU (src2!=0 for DIVU) -> ITER, counter loaded with WIDTH, busy_o=1 from next cycle.
REQ-020 ITER: one shift-add (MULU) or restoring-subtract step (DIVU) per cycle; counter decrements; at count 1 -> DONE.
REQ-021 Latency: single-cycle ops done_o 1 cycle after acceptance; MULU/DIVU done_o exactly WIDTH+1 cycles after acceptance.
REQ-022 DONE without start_i -> IDLE; back-to-back start in DONE SHALL be accepted with no bubble.
REQ-023 start_i while busy_o=1 SHALL be ignored; operands/opcode not resampled.
REQ-024 Outputs result_o, result_hi_o, zero_o, overflow_o, div0_o SHALL hold last values until next done_o; no change during ITER.
REQ-025 ADD/SUB modulo 2**WIDTH; overflow_o=1 when operand signs (B inverted for SUB) match and result sign differs.
REQ-026 SLT/SLTU result_o = {WIDTH-1 zeros, flag}.
REQ-027 MULU: unsigned 2*WIDTH product; result_hi_o high half, result_o low half.
REQ-028 DIVU src2=0: completes in 1 cycle via DONE, result_o all ones, result_hi_o=src1, div0_o=1.
REQ-029 Single-cycle ops drive result_hi_o=0.

Reset
REQ-030 rst_i low, any state, SHALL immediately force IDLE, counter 0, all outputs 0 (zero_o 0), including mid-ITER; no done_o for aborted op.
REQ-031 After rst_i release, first start_i on first rising edge SHALL be accepted.

Verification (WIDTH=32)
REQ-032 ADD 0x7FFFFFFF+1 -> done_o next cycle, result_o=0x80000000, overflow_o=1, zero_o=0.
REQ-033 SUB 5-5 then back-to-back SLT 0xFFFFFFFF,1 -> result_o=0 zero_o=1, next cycle result_o=1 (SLTU same operands -> 0).
REQ-034 MULU 0xFFFFFFFF*0xFFFFFFFF -> busy_o 32 cycles, done_o at cycle 33, result_hi_o=0xFFFFFFFE, result_o=0x00000001; start_i pulsed mid-op ignored.
REQ-035 DIVU 100/7 -> done_o at cycle 33, result_o=14, result_hi_o=2; DIVU 9/0 -> done_o cycle 1, result_o=0xFFFFFFFF, result_hi_o=9, div0_o=1.
REQ-036 Assert rst_i low at ITER cycle 10 of MULU -> outputs 0 same cycle, busy_o=0, no done_o; new ADD after release completes normally.
